serial_magnitude_comparator: RTL

//  Bit-serial N-bit magnitude comparator; consumes per-bit lt/gt/eq flags from
//  the 1-bit comparator (one_bit_comparator_using_mux4x1), MSB first.

---
 rtl/serial_magnitude_comparator_if.sv | 30 +++
 rtl/serial_magnitude_comparator.sv | 96 +++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator_if.sv
// Bit-slice flag stream and word-level verdict for the serial magnitude comparator.
// The master drives the per-bit flags and start; the slave returns the status and the result.
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             start;
  logic             bit_valid;
  logic             bit_lt;
  logic             bit_gt;
  logic             bit_eq;
  logic             busy;
  logic             done;
  logic             lt;
  logic             gt;
  logic             eq;
  logic             err;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output start, bit_valid, bit_lt, bit_gt, bit_eq,
    input  busy, done, lt, gt, eq, err, bit_cnt
  );

  modport slave (
    input  start, bit_valid, bit_lt, bit_gt, bit_eq,
    output busy, done, lt, gt, eq, err, bit_cnt
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: folds MSB-first per-bit lt/gt/eq flags into a
// word verdict, with a sticky error for flag sets that are not one-hot.
module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  serial_magnitude_comparator_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             decided_q, dir_gt_q, err_q, done_q;
  logic [2:0]       result_q;

  logic accept, last_bit, one_hot, decided_nxt, dir_gt_nxt;

  // start always wins over a bit presented in the same cycle.
  always_comb begin
    accept   = (state == COMPARE) && bus.bit_valid && !bus.start;
    last_bit = (bit_cnt_q == CNT_W'(WIDTH - 1));
    one_hot  = (bus.bit_lt ^ bus.bit_gt ^ bus.bit_eq) &&
               !(bus.bit_lt && bus.bit_gt && bus.bit_eq);
  end

  // NOTE: every variable written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    decided_nxt = decided_q;
    dir_gt_nxt  = dir_gt_q;
    if (one_hot && !decided_q && !bus.bit_eq) begin
      decided_nxt = 1'b1;
      dir_gt_nxt  = bus.bit_gt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = COMPARE;
      COMPARE: if (!bus.start && accept && last_bit) state_nxt = DONE;
      DONE:    if (bus.start) state_nxt = COMPARE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      decided_q <= 1'b0;
      dir_gt_q  <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 3'b000;
    end else begin
      done_q <= 1'b0;
      if (bus.start) begin
        bit_cnt_q <= '0;
        decided_q <= 1'b0;
        dir_gt_q  <= 1'b0;
        err_q     <= 1'b0;
        result_q  <= 3'b000;
      end else if (accept) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
        decided_q <= decided_nxt;
        dir_gt_q  <= dir_gt_nxt;
        if (!one_hot) err_q <= 1'b1;
        if (last_bit) begin
          done_q   <= 1'b1;
          // {lt,gt,eq}: the final bit may itself be the deciding one.
          result_q <= decided_nxt ? (dir_gt_nxt ? 3'b010 : 3'b100) : 3'b001;
        end
      end
    end
  end

  always_comb begin
    bus.busy    = (state == COMPARE);
    bus.done    = done_q;
    bus.lt      = result_q[2];
    bus.gt      = result_q[1];
    bus.eq      = result_q[0];
    bus.err     = err_q;
    bus.bit_cnt = bit_cnt_q;
  end
endmodule
